dir_mode_ring_counter: RTL and testbench



---
 rtl/ring_counter_pkg.sv | 15 +
 rtl/ring_state_decode.sv | 97 +++++++++
 rtl/dir_mode_ring_counter.sv | 95 +++++++++
 tb/tb_dir_mode_ring_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the direction/mode ring counter family.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Width of the position index: enough to count the 2*WIDTH Johnson states.
    function automatic int calc_pw(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/ring_state_decode.sv
// Combinational decoder for the counter state.
// Reports legality, sequence position and first/last markers under the current mode.
module ring_state_decode
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = calc_pw(WIDTH)
) (
    input  logic [WIDTH-1:0] out,
    input  logic             mode,
    output logic             legal,
    output logic [PW-1:0]    pos,
    output logic             last,
    output logic             first
);

    // Number of set bits in v.
    function automatic logic [7:0] popcount(input logic [WIDTH-1:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

    // True when v is a run of ones starting at bit 0 (all-zero included).
    function automatic logic is_low_mask(input logic [WIDTH-1:0] v);
        return ((v & (v + {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    endfunction

    // Bit index of a one-hot value (OR-accumulate is exact for one-hot input).
    function automatic logic [7:0] onehot_index(input logic [WIDTH-1:0] v);
        logic [7:0] idx;
        idx = 8'd0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | (v[i] ? 8'(i) : 8'd0);
        end
        return idx;
    endfunction

    logic [7:0] ones_s;
    logic [7:0] ring_idx_s;
    logic [7:0] john_idx_s;
    logic [7:0] idx_s;
    logic [7:0] last_idx_s;
    logic       ring_legal_s;
    logic       john_legal_s;

    // Decode legality and index for both modes, then select by mode.
    always_comb begin
        ones_s       = popcount(out);
        ring_legal_s = (ones_s == 8'd1);
        // A twisted-ring state has its ones packed against bit 0 or against the MSB.
        john_legal_s = is_low_mask(out) || is_low_mask(~out);
        ring_idx_s   = onehot_index(out);
        if (out == {WIDTH{1'b0}}) begin
            john_idx_s = 8'd0;
        end else if (out[0]) begin
            john_idx_s = ones_s;
        end else begin
            john_idx_s = 8'(2 * WIDTH) - ones_s;
        end

        legal      = 1'b0;
        idx_s      = 8'd0;
        last_idx_s = 8'd0;
        case (mode)
            MODE_RING: begin
                legal      = ring_legal_s;
                idx_s      = ring_idx_s;
                last_idx_s = 8'(WIDTH - 1);
            end
            MODE_JOHNSON: begin
                legal      = john_legal_s;
                idx_s      = john_idx_s;
                last_idx_s = 8'(2 * WIDTH - 1);
            end
            default: begin
                legal      = 1'b0;
                idx_s      = 8'd0;
                last_idx_s = 8'd0;
            end
        endcase

        if (legal) begin
            pos   = idx_s[PW-1:0];
            first = (idx_s == 8'd0);
            last  = (idx_s == last_idx_s);
        end else begin
            pos   = {PW{1'b0}};
            first = 1'b0;
            last  = 1'b0;
        end
    end

endmodule

// File: rtl/dir_mode_ring_counter.sv
// One-hot / Johnson ring counter with direction, enable, parallel load,
// wrap pulse and self-correction from illegal states.
module dir_mode_ring_counter
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = calc_pw(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    pos,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_r;
    logic             tc_r;
    logic             err_r;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] out_nx_s;
    logic             tc_nx_s;
    logic             err_nx_s;
    logic             legal_s;
    logic             last_s;
    logic             first_s;

    ring_state_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .out   (out_r),
        .mode  (mode),
        .legal (legal_s),
        .pos   (pos),
        .last  (last_s),
        .first (first_s)
    );

    // Shifted value for a legal step in the selected mode and direction.
    always_comb begin
        case ({mode, dir})
            {MODE_RING,    DIR_FWD}: step_s = {out_r[WIDTH-2:0], out_r[WIDTH-1]};
            {MODE_RING,    DIR_REV}: step_s = {out_r[0], out_r[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_FWD}: step_s = {out_r[WIDTH-2:0], ~out_r[WIDTH-1]};
            {MODE_JOHNSON, DIR_REV}: step_s = {~out_r[0], out_r[WIDTH-1:1]};
            default:                 step_s = RESET_VAL;
        endcase
    end

    // Next-state selection: load beats enable; enable steps or corrects; otherwise hold.
    always_comb begin
        out_nx_s = out_r;
        tc_nx_s  = 1'b0;
        err_nx_s = 1'b0;
        if (load) begin
            out_nx_s = load_val;
        end else if (en) begin
            if (legal_s) begin
                out_nx_s = step_s;
                // Wrap is leaving the last index going forward or index 0 going backward.
                tc_nx_s  = (dir == DIR_FWD) ? last_s : first_s;
            end else begin
                out_nx_s = RESET_VAL;
                err_nx_s = 1'b1;
            end
        end else begin
            out_nx_s = out_r;
        end
    end

    // State and pulse registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_r <= RESET_VAL;
            tc_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            out_r <= out_nx_s;
            tc_r  <= tc_nx_s;
            err_r <= err_nx_s;
        end
    end

    assign out = out_r;
    assign tc  = tc_r;
    assign err = err_r;

endmodule

// File: tb/tb_dir_mode_ring_counter.sv
// Table-driven scoreboard bench for dir_mode_ring_counter at WIDTH=4.
module tb_dir_mode_ring_counter;

    localparam int W  = 4;
    localparam int PW = 3;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          dir;
    logic          mode;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  out;
    logic [PW-1:0] pos;
    logic          tc;
    logic          err;

    dir_mode_ring_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .pos      (pos),
        .tc       (tc),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic          dir;
        logic          mode;
        logic          load;
        logic [W-1:0]  lv;
        logic [W-1:0]  eo;
        logic [PW-1:0] ep;
        logic          et;
        logic          ee;
    } vec_t;

    typedef struct packed {
        logic [W-1:0]  eo;
        logic [PW-1:0] ep;
        logic          et;
        logic          ee;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic add(input logic e, input logic d, input logic m, input logic l,
                       input logic [W-1:0] lv, input logic [W-1:0] eo,
                       input logic [PW-1:0] ep, input logic et, input logic ee);
        vec_t v;
        v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv;
        v.eo = eo; v.ep = ep; v.et = et; v.ee = ee;
        vecs.push_back(v);
    endtask

    // Drive one vector, push its expectation, wait one edge and compare.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t g;
        en = v.en; dir = v.dir; mode = v.mode; load = v.load; load_val = v.lv;
        e.eo = v.eo; e.ep = v.ep; e.et = v.et; e.ee = v.ee;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d_queue", idx), 0, 1);
        end else begin
            g = exp_q.pop_front();
            chk($sformatf("v%0d_out", idx), int'(out), int'(g.eo));
            chk($sformatf("v%0d_pos", idx), int'(pos), int'(g.ep));
            chk($sformatf("v%0d_tc",  idx), int'(tc),  int'(g.et));
            chk($sformatf("v%0d_err", idx), int'(err), int'(g.ee));
        end
    endtask

    // Assert reset between edges and check the immediate clear.
    task automatic mid_reset(input string name, input logic [PW-1:0] ep);
        #3;
        rstn = 1'b0;
        #1;
        chk({name, "_out"}, int'(out), 1);
        chk({name, "_pos"}, int'(pos), int'(ep));
        chk({name, "_tc"},  int'(tc),  0);
        chk({name, "_err"}, int'(err), 0);
        #1;
        rstn = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out", int'(out), 1);
        chk("rst_pos", int'(pos), 0);
        chk("rst_tc",  int'(tc),  0);
        chk("rst_err", int'(err), 0);
        rstn = 1'b1;

        //   en    dir   mode  load  load_val exp_out  pos   tc    err
        // ring forward
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 3'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 3'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd0, 1'b1, 1'b0);
        // ring reverse
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd3, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 3'd2, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 3'd1, 1'b0, 1'b0);
        // illegal load, correction, hold
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0110, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd0, 1'b0, 1'b0);
        // legal load then step
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 3'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd3, 1'b0, 1'b0);
        // hold for 5 cycles
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1000, 3'd3, 1'b0, 1'b0);
        // load wins over enable
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0010, 3'd1, 1'b0, 1'b0);
        // ring 0100 becomes illegal under Johnson
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 3'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b1);
        // Johnson forward through a full cycle
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0011, 3'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0111, 3'd3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd4, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100, 3'd6, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1000, 3'd7, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b0);
        // Johnson reverse
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 3'd7, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1100, 3'd6, 1'b0, 1'b0);
        // Johnson-illegal value corrected
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'b0101, 4'b0101, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b1);
        // Johnson-legal 0011 is illegal in ring mode
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 4'b0011, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset while err is high.
        mid_reset("mrst_err", 3'd0);

        // Load 0111 in Johnson, then reset between edges.
        begin
            vec_t v;
            v = '0;
            v.load = 1'b1; v.mode = 1'b1; v.lv = 4'b0111;
            v.eo = 4'b0111; v.ep = 3'd3;
            apply(v, 100);
        end
        mid_reset("mrst_j", 3'd1);

        // Consecutive ring wraps: tc every 4 cycles.
        begin
            int tc_seen;
            tc_seen = 0;
            en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (tc) tc_seen++;
                if (i % 4 == 3) chk($sformatf("wrap_tc%0d", i), int'(tc), 1);
            end
            chk("wrap_count", tc_seen, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
